// File: rtl/data_bus_responder.sv
// Purpose: data-bus responder that decodes scratch RAM, an output FIFO with a drain port, and a cycle counter.
// Latency: read data appears on q one clock after the address is sampled; pushes reach out_valid one clock later.
// Backpressure: out_ready low holds the FIFO head; pushes to a full FIFO are dropped and set the sticky overflow flag.
module data_bus_responder #(
  parameter int RAM_AW  = 8,
  parameter int FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [15:0] data,
  input  logic        wren,
  output logic [15:0] q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        overflow
);

  localparam int          RAM_WORDS  = 1 << RAM_AW;
  localparam int          DEPTH      = 1 << FIFO_AW;
  localparam logic [15:0] ADDR_OUT   = 16'hFF00;
  localparam logic [15:0] ADDR_STAT  = 16'hFF01;
  localparam logic [15:0] ADDR_CYCLE = 16'hFF02;

  // Storage: scratch RAM and FIFO word array carry no reset.
  logic [15:0] ram_mem  [RAM_WORDS];
  logic [15:0] fifo_mem [DEPTH];

  // Registered state and next-state values.
  logic [15:0]        q_q, q_d;
  logic [15:0]        cycle_q, cycle_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  // Decode and handshake terms.
  logic        ram_hit;
  logic        ram_we;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        drop;
  logic        stat_wr;
  logic        cycle_wr;
  logic        empty;
  logic        full;
  logic [15:0] stat_word;

  assign ram_hit  = ({16'h0000, address} < 32'(RAM_WORDS));
  assign ram_we   = wren && ram_hit;
  assign push_req = wren && (address == ADDR_OUT);
  assign stat_wr  = wren && (address == ADDR_STAT);
  assign cycle_wr = wren && (address == ADDR_CYCLE);

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH[FIFO_AW:0]);

  // Full is judged before the edge, so a same-cycle pop never frees room for the push.
  assign push = push_req && !full;
  assign drop = push_req && full;
  assign pop  = !empty && out_ready;

  assign stat_word = {8'(count_q), 5'b00000, overflow_q, full, empty};

  assign q         = q_q;
  assign out_valid = !empty;
  assign out_data  = empty ? 16'h0000 : fifo_mem[rd_ptr_q];
  assign overflow  = overflow_q;

  // Read mux: every cycle samples the addressed target using pre-edge state.
  always_comb begin
    q_d = 16'h0000;
    if (ram_hit) begin
      q_d = ram_mem[address[RAM_AW-1:0]];
    end else begin
      case (address)
        ADDR_STAT:  q_d = stat_word;
        ADDR_CYCLE: q_d = cycle_q;
        default:    q_d = 16'h0000;
      endcase
    end
  end

  // FIFO pointer/count, overflow flag and counter next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    cycle_d    = cycle_q + 16'h0001;

    if (push) begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase

    // A dropped push in the same cycle as a clear leaves the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (stat_wr && data[2]) begin
      overflow_d = 1'b0;
    end

    if (cycle_wr) begin
      cycle_d = data;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q        <= 16'h0000;
      cycle_q    <= 16'h0000;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      cycle_q    <= cycle_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Scratch RAM write; the read mux sees the old word during the writing cycle.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_mem[address[RAM_AW-1:0]] <= data;
    end
  end

  // FIFO word write at the tail pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= data;
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: RAM, FIFO drain/overflow, cycle counter and reset.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
// Each scenario task performs its own inline comparisons.
module tb_data_bus_responder;

  localparam logic [15:0] IDLE = 16'h8000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = 16'h0000;
  logic [15:0] data = 16'h0000;
  logic        wren = 1'b0;
  logic [15:0] q;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        overflow;

  int total = 0;
  int bad = 0;

  data_bus_responder #(.RAM_AW(8), .FIFO_AW(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .data      (data),
    .wren      (wren),
    .q         (q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Present one bus access for one clock, then settle 1 ns past the edge.
  task automatic bus(input logic [15:0] a, input logic [15:0] d, input logic w);
    address = a;
    data    = d;
    wren    = w;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++; if (q !== 16'h0000) begin bad++; $display("FAIL reset_q got=%h want=0000", q); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%h want=0000", out_data); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    reset = 1'b0;
    bus(16'hFF02, 16'h0000, 1'b0);
    total++; if (q !== 16'h0000) begin bad++; $display("FAIL reset_cycle0 got=%h want=0000", q); end
    bus(16'hFF02, 16'h0000, 1'b0);
    total++; if (q !== 16'h0001) begin bad++; $display("FAIL reset_cycle1 got=%h want=0001", q); end
  endtask

  task automatic test_ram;
    bus(16'h0005, 16'h1234, 1'b1);
    bus(16'h0005, 16'h0000, 1'b0);
    total++; if (q !== 16'h1234) begin bad++; $display("FAIL ram_read got=%h want=1234", q); end
    bus(16'h0005, 16'hBEEF, 1'b1);
    total++; if (q !== 16'h1234) begin bad++; $display("FAIL ram_rdw_old got=%h want=1234", q); end
    bus(16'h0005, 16'h0000, 1'b0);
    total++; if (q !== 16'hBEEF) begin bad++; $display("FAIL ram_read_new got=%h want=beef", q); end
  endtask

  task automatic test_fifo_fill;
    logic [15:0] exp;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fill_empty_valid got=%b want=0", out_valid); end
    for (int i = 1; i <= 8; i++) begin
      exp = 16'hA000 + 16'(i);
      bus(16'hFF00, exp, 1'b1);
    end
    total++; if (out_valid !== 1'b1 || out_data !== 16'hA001) begin bad++; $display("FAIL fill_head got=%b/%h want=1/a001", out_valid, out_data); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_no_ovf got=%b want=0", overflow); end
    bus(16'hFF00, 16'hA009, 1'b1);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf got=%b want=1", overflow); end
    bus(16'hFF01, 16'h0000, 1'b0);
    total++; if (q !== 16'h0806) begin bad++; $display("FAIL fill_stat got=%h want=0806", q); end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      exp = 16'hA000 + 16'(i);
      total++; if (out_valid !== 1'b1 || out_data !== exp) begin bad++; $display("FAIL drain_%0d got=%b/%h want=1/%h", i, out_valid, out_data, exp); end
      bus(IDLE, 16'h0000, 1'b0);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_push_pop;
    logic [15:0] exp [3];
    exp[0] = 16'hB002; exp[1] = 16'hB003; exp[2] = 16'hC0DE;
    out_ready = 1'b0;
    bus(16'hFF00, 16'hB001, 1'b1);
    bus(16'hFF00, 16'hB002, 1'b1);
    bus(16'hFF00, 16'hB003, 1'b1);
    out_ready = 1'b1;
    bus(16'hFF00, 16'hC0DE, 1'b1);
    out_ready = 1'b0;
    bus(16'hFF01, 16'h0000, 1'b0);
    total++; if (q !== 16'h0304) begin bad++; $display("FAIL pp_stat got=%h want=0304", q); end
    bus(16'hFF01, 16'h0004, 1'b1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pp_clear_ovf got=%b want=0", overflow); end
    bus(16'hFF01, 16'h0000, 1'b0);
    total++; if (q !== 16'h0300) begin bad++; $display("FAIL pp_stat2 got=%h want=0300", q); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin bad++; $display("FAIL pp_order_%0d got=%b/%h want=1/%h", i, out_valid, out_data, exp[i]); end
      bus(IDLE, 16'h0000, 1'b0);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pp_empty got=%b want=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_hold_full;
    logic [15:0] exp;
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      exp = 16'hD000 + 16'(i);
      bus(16'hFF00, exp, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== 16'hD001) begin bad++; $display("FAIL hold_%0d got=%b/%h want=1/d001", i, out_valid, out_data); end
      bus(IDLE, 16'h0000, 1'b0);
    end
    out_ready = 1'b1;
    bus(16'hFF00, 16'hEEEE, 1'b1);
    out_ready = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_pp_ovf got=%b want=1", overflow); end
    bus(16'hFF01, 16'h0000, 1'b0);
    total++; if (q !== 16'h0704) begin bad++; $display("FAIL full_pp_stat got=%h want=0704", q); end
    out_ready = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      exp = 16'hD000 + 16'(i);
      total++; if (out_valid !== 1'b1 || out_data !== exp) begin bad++; $display("FAIL full_pp_drain_%0d got=%b/%h want=1/%h", i, out_valid, out_data, exp); end
      bus(IDLE, 16'h0000, 1'b0);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_pp_empty got=%b want=0", out_valid); end
    out_ready = 1'b0;
    bus(16'hFF01, 16'h0004, 1'b1);
  endtask

  task automatic test_cycle;
    logic [15:0] c1;
    logic [15:0] c2;
    bus(16'hFF02, 16'h0000, 1'b0);
    c1 = q;
    repeat (9) bus(16'hFF02, 16'h0000, 1'b0);
    bus(16'hFF02, 16'h0000, 1'b0);
    c2 = q;
    total++; if (16'(c2 - c1) !== 16'd10) begin bad++; $display("FAIL cycle_delta got=%0d want=10", 16'(c2 - c1)); end
    bus(16'hFF02, 16'hFFFE, 1'b1);
    bus(16'hFF02, 16'h0000, 1'b0);
    total++; if (q !== 16'hFFFE) begin bad++; $display("FAIL cycle_load got=%h want=fffe", q); end
    bus(16'hFF02, 16'h0000, 1'b0);
    total++; if (q !== 16'hFFFF) begin bad++; $display("FAIL cycle_ffff got=%h want=ffff", q); end
    bus(16'hFF02, 16'h0000, 1'b0);
    total++; if (q !== 16'h0000) begin bad++; $display("FAIL cycle_wrap got=%h want=0000", q); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      bus(16'hFF00, 16'hF000 + 16'(i), 1'b1);
    end
    bus(16'h0005, 16'h0000, 1'b0);
    total++; if (q !== 16'hBEEF || overflow !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset got=%h/%b/%b want=beef/1/1", q, overflow, out_valid); end
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b want=0", out_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_reset_ovf got=%b want=0", overflow); end
    total++; if (q !== 16'h0000) begin bad++; $display("FAIL mid_reset_q got=%h want=0000", q); end
    total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL mid_reset_out_data got=%h want=0000", out_data); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus(IDLE, 16'h5555, 1'b1);
    total++; if (q !== 16'h0000) begin bad++; $display("FAIL unmapped_read got=%h want=0000", q); end
    bus(16'h0005, 16'h0000, 1'b0);
    total++; if (q !== 16'hBEEF) begin bad++; $display("FAIL ram_kept got=%h want=beef", q); end
    bus(16'hFF01, 16'h0000, 1'b0);
    total++; if (q !== 16'h0001) begin bad++; $display("FAIL post_reset_stat got=%h want=0001", q); end
    bus(16'hFF00, 16'h0000, 1'b0);
    total++; if (q !== 16'h0000) begin bad++; $display("FAIL out_data_read got=%h want=0000", q); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_fifo_fill();
    test_push_pop();
    test_hold_full();
    test_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
